// File: rtl/cpu_pkg.sv
// Shared CPU constants and the write-back arbiter's grant encoding.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Starvation counter width and its saturation value
  localparam int unsigned  WAIT_CNT_W = 4;
  localparam logic [3:0]   WAIT_SAT   = 4'd15;

  // Which requester owns the write port in the current cycle
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_M    = 2'd1,
    GRANT_E    = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the write-back requester handshakes, register-file write port
// and forwarding outputs. "master" is the pipeline / register-file side,
// "slave" is the arbiter itself.
interface wb_arbiter_if;
  import cpu_pkg::*;

  logic                  m_valid;
  logic [REG_ADDR_W-1:0] m_rd;
  logic [XLEN-1:0]       m_data;
  logic                  m_ready;

  logic                  e_valid;
  logic [REG_ADDR_W-1:0] e_rd;
  logic [XLEN-1:0]       e_data;
  logic                  e_ready;

  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;

  logic                  write_reg;
  logic [REG_ADDR_W-1:0] target_reg;
  logic [XLEN-1:0]       write_rd_data;

  logic                  fwd1_hit;
  logic                  fwd2_hit;
  logic [XLEN-1:0]       fwd_data;
  logic                  conflict;

  modport master (
    output m_valid, m_rd, m_data, e_valid, e_rd, e_data, rs1, rs2,
    input  m_ready, e_ready, write_reg, target_reg, write_rd_data,
           fwd1_hit, fwd2_hit, fwd_data, conflict
  );

  modport slave (
    input  m_valid, m_rd, m_data, e_valid, e_rd, e_data, rs1, rs2,
    output m_ready, e_ready, write_reg, target_reg, write_rd_data,
           fwd1_hit, fwd2_hit, fwd_data, conflict
  );

endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: two requesters (memory-stage loads M, execute results E)
// share one register-file write port. M has priority unless E has been
// refused for MAX_WAIT consecutive cycles. The winner is captured in an
// output register that drives the register file and the forwarding muxes.
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter_if.slave   bus
);

  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_V = WAIT_CNT_W'(MAX_WAIT);

  grant_e                grant;
  logic                  e_prio;

  logic                  write_reg_q,  write_reg_d;
  logic [REG_ADDR_W-1:0] target_reg_q, target_reg_d;
  logic [XLEN-1:0]       wr_data_q,    wr_data_d;
  logic                  conflict_q,   conflict_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q,   wait_cnt_d;

  // Pick the winner: M by default, E once starved, nobody while in reset
  always_comb begin
    grant  = GRANT_NONE;
    e_prio = (wait_cnt_q >= MAX_WAIT_V);
    if (!rst) begin
      if (bus.m_valid && !(bus.e_valid && e_prio)) begin
        grant = GRANT_M;
      end else if (bus.e_valid) begin
        grant = GRANT_E;
      end
    end
    bus.m_ready = (grant == GRANT_M);
    bus.e_ready = (grant == GRANT_E);
  end

  // Next values for the output register, conflict flag and starvation counter
  always_comb begin
    write_reg_d  = 1'b0;
    target_reg_d = target_reg_q;
    wr_data_d    = wr_data_q;
    conflict_d   = bus.m_valid && bus.e_valid &&
                   (bus.m_rd == bus.e_rd) && (bus.m_rd != REG_ZERO);
    wait_cnt_d   = '0;

    if (bus.e_valid && (grant != GRANT_E)) begin
      wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? WAIT_SAT : wait_cnt_q + 4'd1;
    end

    // x0 writes are consumed and recorded but never raise the write enable
    case (grant)
      GRANT_M: begin
        target_reg_d = bus.m_rd;
        wr_data_d    = bus.m_data;
        write_reg_d  = (bus.m_rd != REG_ZERO);
      end
      GRANT_E: begin
        target_reg_d = bus.e_rd;
        wr_data_d    = bus.e_data;
        write_reg_d  = (bus.e_rd != REG_ZERO);
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset; reset also drops any pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      write_reg_q  <= 1'b0;
      target_reg_q <= '0;
      wr_data_q    <= '0;
      conflict_q   <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      write_reg_q  <= write_reg_d;
      target_reg_q <= target_reg_d;
      wr_data_q    <= wr_data_d;
      conflict_q   <= conflict_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Register-file drive and forwarding of the in-flight write until the
  // falling-edge commit makes it visible through the normal read path
  always_comb begin
    bus.write_reg     = write_reg_q;
    bus.target_reg    = target_reg_q;
    bus.write_rd_data = wr_data_q;
    bus.fwd_data      = wr_data_q;
    bus.conflict      = conflict_q;
    bus.fwd1_hit      = write_reg_q && (bus.rs1 == target_reg_q) &&
                        (bus.rs1 != REG_ZERO);
    bus.fwd2_hit      = write_reg_q && (bus.rs2 == target_reg_q) &&
                        (bus.rs2 != REG_ZERO);
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a vector table for single-cycle
// behaviour plus hand sequences for starvation and mid-stream reset.
// Expected register outputs are queued when a vector is driven and popped
// one clock later when the output register has updated.
module tb_wb_arbiter;
  import cpu_pkg::*;

  typedef struct {
    logic        rst;
    logic        m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        exp_m_ready;
    logic        exp_e_ready;
    logic        exp_fwd1;
    logic        exp_fwd2;
    logic        exp_wr;
    logic [4:0]  exp_tgt;
    logic [31:0] exp_data;
    logic        exp_conflict;
    logic        chk_reg;
    logic [4:0]  reg_idx;
    logic [31:0] reg_val;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [4:0]  tgt;
    logic [31:0] data;
    logic        conflict;
  } exp_out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] reg_file [32] = '{default: 32'h0};
  exp_out_t    exp_q [$];
  vec_t        vecs [$];
  int          assert_count = 0;
  int          fail_count   = 0;

  wb_arbiter_if bus_if ();

  wb_arbiter #(.MAX_WAIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Register-file model: commits the in-flight write at the falling edge
  always @(negedge clk) begin
    if (bus_if.write_reg) reg_file[bus_if.target_reg] <= bus_if.write_rd_data;
  end

  // Hard stop in case the run ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pop the expected output register contents and compare
  task automatic checkOutput();
    exp_out_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("write_reg",     {31'd0, bus_if.write_reg}, {31'd0, e.wr});
      check("target_reg",    {27'd0, bus_if.target_reg}, {27'd0, e.tgt});
      check("write_rd_data", bus_if.write_rd_data, e.data);
      check("fwd_data",      bus_if.fwd_data, e.data);
      check("conflict",      {31'd0, bus_if.conflict}, {31'd0, e.conflict});
    end
  endtask

  // Drive one cycle of inputs, check combinational outputs, then clock it
  task automatic applyStimulus(input vec_t v);
    exp_out_t e;
    rst            = v.rst;
    bus_if.m_valid = v.m_valid;
    bus_if.m_rd    = v.m_rd;
    bus_if.m_data  = v.m_data;
    bus_if.e_valid = v.e_valid;
    bus_if.e_rd    = v.e_rd;
    bus_if.e_data  = v.e_data;
    bus_if.rs1     = v.rs1;
    bus_if.rs2     = v.rs2;
    #2;
    check("m_ready",  {31'd0, bus_if.m_ready},  {31'd0, v.exp_m_ready});
    check("e_ready",  {31'd0, bus_if.e_ready},  {31'd0, v.exp_e_ready});
    check("fwd1_hit", {31'd0, bus_if.fwd1_hit}, {31'd0, v.exp_fwd1});
    check("fwd2_hit", {31'd0, bus_if.fwd2_hit}, {31'd0, v.exp_fwd2});
    e.wr       = v.exp_wr;
    e.tgt      = v.exp_tgt;
    e.data     = v.exp_data;
    e.conflict = v.exp_conflict;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
    if (v.chk_reg) check($sformatf("regfile_x%0d", v.reg_idx), reg_file[v.reg_idx], v.reg_val);
  endtask

  initial begin
    vec_t v;
    int   m_idx;
    int   e_idx;
    logic grant_e_exp;
    logic [3:0] exp_wait;

    // Reset with both requesters valid: nobody may be accepted
    rst            = 1'b1;
    bus_if.m_valid = 1'b1;
    bus_if.m_rd    = 5'd3;
    bus_if.m_data  = 32'h3;
    bus_if.e_valid = 1'b1;
    bus_if.e_rd    = 5'd4;
    bus_if.e_data  = 32'h4;
    bus_if.rs1     = 5'd0;
    bus_if.rs2     = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_write_reg",  {31'd0, bus_if.write_reg}, 32'd0);
    check("reset_target_reg", {27'd0, bus_if.target_reg}, 32'd0);
    check("reset_wr_data",    bus_if.write_rd_data, 32'd0);
    check("reset_conflict",   {31'd0, bus_if.conflict}, 32'd0);
    check("reset_m_ready",    {31'd0, bus_if.m_ready}, 32'd0);
    check("reset_e_ready",    {31'd0, bus_if.e_ready}, 32'd0);
    check("reset_wait_cnt",   {28'd0, dut.wait_cnt_q}, 32'd0);

    // rst mv mrd mdata  ev erd edata  rs1 rs2  mr er f1 f2  wr tgt data cf  chk idx val
    vecs.push_back('{0, 0,0,32'h0,         1,5,32'h1234, 0,0, 0,1,0,0, 1,5,32'h1234,    0, 0,0,32'h0});
    vecs.push_back('{0, 0,0,32'h0,         0,0,32'h0,    5,5, 0,0,1,1, 0,5,32'h1234,    0, 1,5,32'h1234});
    vecs.push_back('{0, 1,0,32'hFFFF_FFFF, 0,0,32'h0,    0,0, 1,0,0,0, 0,0,32'hFFFF_FFFF,0, 0,0,32'h0});
    vecs.push_back('{0, 1,9,32'h99,        0,0,32'h0,    9,0, 1,0,0,0, 1,9,32'h99,      0, 1,0,32'h0});
    vecs.push_back('{0, 0,0,32'h0,         0,0,32'h0,    9,0, 0,0,1,0, 0,9,32'h99,      0, 1,9,32'h99});
    vecs.push_back('{0, 1,7,32'hAAAA,      1,7,32'hBBBB, 0,0, 1,0,0,0, 1,7,32'hAAAA,    1, 0,0,32'h0});
    vecs.push_back('{0, 0,0,32'h0,         1,7,32'hBBBB, 7,0, 0,1,1,0, 1,7,32'hBBBB,    0, 1,7,32'hAAAA});
    vecs.push_back('{0, 0,0,32'h0,         0,0,32'h0,    0,0, 0,0,0,0, 0,7,32'hBBBB,    0, 1,7,32'hBBBB});
    vecs.push_back('{0, 1,0,32'h1,         1,0,32'h2,    0,0, 1,0,0,0, 0,0,32'h1,       0, 0,0,32'h0});
    vecs.push_back('{0, 0,0,32'h0,         1,0,32'h2,    0,0, 0,1,0,0, 0,0,32'h2,       0, 1,0,32'h0});

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Starvation guard: both valid for 8 cycles gives M,M,M,E,M,M,M,E
    m_idx = 0;
    e_idx = 0;
    for (int i = 0; i < 8; i++) begin
      grant_e_exp    = ((i % 4) == 3);
      v              = '{default: '0};
      v.m_valid      = 1'b1;
      v.m_rd         = 5'(10 + m_idx);
      v.m_data       = 32'hA000 + 32'(m_idx);
      v.e_valid      = 1'b1;
      v.e_rd         = 5'd20;
      v.e_data       = 32'hB000 + 32'(e_idx);
      v.exp_m_ready  = !grant_e_exp;
      v.exp_e_ready  = grant_e_exp;
      v.exp_wr       = 1'b1;
      v.exp_tgt      = grant_e_exp ? v.e_rd : v.m_rd;
      v.exp_data     = grant_e_exp ? v.e_data : v.m_data;
      applyStimulus(v);
      if (grant_e_exp) e_idx++;
      else m_idx++;
      exp_wait = grant_e_exp ? 4'd0 : 4'((i % 4) + 1);
      check($sformatf("starve_wait_cnt_%0d", i), {28'd0, dut.wait_cnt_q}, {28'd0, exp_wait});
    end

    // Reset in the cycle after an accepted write, with a nonzero wait count
    v             = '{default: '0};
    v.m_valid     = 1'b1;
    v.m_rd        = 5'd12;
    v.m_data      = 32'hC;
    v.e_valid     = 1'b1;
    v.e_rd        = 5'd13;
    v.e_data      = 32'hD;
    v.exp_m_ready = 1'b1;
    v.exp_wr      = 1'b1;
    v.exp_tgt     = 5'd12;
    v.exp_data    = 32'hC;
    applyStimulus(v);
    check("pre_reset_wait_cnt", {28'd0, dut.wait_cnt_q}, 32'd1);

    v             = '{default: '0};
    v.rst         = 1'b1;
    v.m_valid     = 1'b1;
    v.m_rd        = 5'd14;
    v.m_data      = 32'hE;
    v.e_valid     = 1'b1;
    v.e_rd        = 5'd13;
    v.e_data      = 32'hD;
    v.rs1         = 5'd12;
    v.exp_fwd1    = 1'b1;
    applyStimulus(v);
    v.exp_fwd1    = 1'b0;
    applyStimulus(v);
    check("release_wait_cnt", {28'd0, dut.wait_cnt_q}, 32'd0);

    v.rst         = 1'b0;
    v.rs1         = 5'd0;
    v.exp_m_ready = 1'b1;
    v.exp_wr      = 1'b1;
    v.exp_tgt     = 5'd14;
    v.exp_data    = 32'hE;
    applyStimulus(v);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
